// File: rtl/sw_scan_ctrl.sv
// Switch-to-display scan controller: sequential double-dabble BCD conversion,
// leading-zero blanking and 4-digit time multiplexing into display_num.
module sw_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 5,
  parameter int unsigned W        = 13
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] SW,
  input  logic [3:0]   dp_en,
  output logic [3:0]   posb,
  output logic [3:0]   num,
  output logic         dp,
  output logic         busy
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BCD_W  = 16;
  localparam int unsigned ITER_W = $clog2(W + 1);
  localparam logic [3:0]  NUM_BLANK = 4'd10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  logic [CNT_W-1:0]  cnt;
  logic [1:0]        pos;

  state_t            state_q, state_d;
  logic [W-1:0]      bin_q, bin_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [W-1:0]      last_sw_q, last_sw_d;
  logic              force_q, force_d;
  logic [BCD_W-1:0]  digits_q, digits_d;

  logic [BCD_W-2:0]  bcd_adj;
  logic              blank1, blank2, blank3;
  logic [3:0]        digit_code;

  // Scan timebase: each digit position is held for SCAN_DIV+1 cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
      pos <= '0;
    end else if (cnt == CNT_W'(SCAN_DIV)) begin
      cnt <= '0;
      pos <= pos + 2'd1;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  // Nibble 3 never needs the +3 step: its final value is <= 9, so it is <= 4 before any shift.
  always_comb begin
    bcd_adj = bcd_q[BCD_W-2:0];
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Converter state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      iter_q    <= '0;
      last_sw_q <= '0;
      force_q   <= 1'b1;
      digits_q  <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      iter_q    <= iter_d;
      last_sw_q <= last_sw_d;
      force_q   <= force_d;
      digits_q  <= digits_d;
      busy      <= (state_d != IDLE);
    end
  end

  // Converter next-state logic; display digits change only on a completed conversion.
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    iter_d    = iter_q;
    last_sw_d = last_sw_q;
    force_d   = force_q;
    digits_d  = digits_q;
    case (state_q)
      IDLE: begin
        if (force_q || (SW != last_sw_q)) begin
          bin_d     = SW;
          last_sw_d = SW;
          force_d   = 1'b0;
          bcd_d     = '0;
          iter_d    = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q, 1'b0};
        iter_d         = iter_q + ITER_W'(1);
        if (iter_q == ITER_W'(W - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        digits_d = bcd_q;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Leading-zero blanking and digit selection for the current scan position.
  always_comb begin
    blank3     = (digits_q[15:12] == 4'd0);
    blank2     = blank3 && (digits_q[11:8] == 4'd0);
    blank1     = blank2 && (digits_q[7:4] == 4'd0);
    digit_code = digits_q[3:0];
    case (pos)
      2'd0: digit_code = digits_q[3:0];
      2'd1: digit_code = blank1 ? NUM_BLANK : digits_q[7:4];
      2'd2: digit_code = blank2 ? NUM_BLANK : digits_q[11:8];
      2'd3: digit_code = blank3 ? NUM_BLANK : digits_q[15:12];
      default: digit_code = NUM_BLANK;
    endcase
  end

  // Registered drive to display_num, one cycle behind pos.
  always_ff @(posedge CLK) begin
    if (RST) begin
      posb <= 4'b1111;
      num  <= NUM_BLANK;
      dp   <= 1'b0;
    end else begin
      posb <= ~(4'b0001 << pos);
      num  <= digit_code;
      dp   <= dp_en[pos];
    end
  end

endmodule

// File: doc/sw_scan_ctrl.md
Name: sw_scan_ctrl

Overview:
- Scan controller that sequences the 4-digit display_num datapath.
- Takes a binary switch value and converts it to BCD with a sequential double-dabble converter.
- Applies leading-zero blanking, then time-multiplexes the digits onto display_num's posb/num/dp inputs.
- Replaces the ad-hoc scan/divide logic with one synthesizable block between the SW inputs and display_num.

Parameters:
- SCAN_DIV, 5: digit hold count; each digit is driven for SCAN_DIV+1 cycles (legal 1..2^16-1).
- W, 13: SW width; max value 2^W-1 must be <= 9999, so W <= 13.

Ports:
- CLK, input, 1: sole clock, rising edge.
- RST, input, 1: synchronous, active-high reset.
- SW, input, W: binary value to display.
- dp_en, input, 4: per-digit decimal-point enable; bit i applies to digit i (0 = rightmost).
- posb, output, 4: active-low digit select to display_num.
- num, output, 4: digit code to display_num; 0-9 = digit, 10 = blank.
- dp, output, 1: decimal point for the currently selected digit.
- busy, output, 1: high while a conversion is in progress.

Behaviour:
- Reset (RST high at a clock edge):
  - cnt=0, pos=0, posb=4'b1111, num=10, dp=0, busy=0.
  - Display digit regs d0..d3 = 0, FSM = IDLE, last_sw = 0, force flag = 1.
  - RST overrides everything, including mid-scan and mid-conversion; any partial conversion is discarded.
- Scan counter:
  - cnt increments each cycle.
  - When cnt==SCAN_DIV: cnt<=0 and pos<=pos+1, wrapping 3->0.
- Output registers (one-cycle lag behind pos):
  - posb: pos0 -> 1110, pos1 -> 1101, pos2 -> 1011, pos3 -> 0111.
  - num <= blanked digit code of pos.
  - dp <= dp_en[pos].
- Leading-zero blanking, evaluated on d0..d3:
  - Digit 3 is blank if d3==0.
  - Digit 2 is blank if d3==0 and d2==0.
  - Digit 1 is blank if d3==0 and d2==0 and d1==0.
  - Digit 0 is never blanked.
  - Interior zeros are displayed, e.g. 105 shows "105", not "1 5".
- Converter FSM:
  - IDLE: if force==1 or SW!=last_sw, then sample SW into the shift reg, last_sw<=SW, force<=0, clear the BCD accumulator, set iter=0, go to SHIFT.
  - SHIFT: per cycle, add 3 to every BCD nibble >=5, then shift {bcd,bin} left by 1 and increment iter. After W iterations go to DONE.
  - DONE: copy the BCD nibbles to d0..d3, go to IDLE.
  - busy=1 in SHIFT and DONE, 0 in IDLE.
- Latency: an SW change sampled in IDLE reaches d0..d3 exactly W+2 cycles later (15 for W=13). It appears on num at the next scan slot of each digit, +1 cycle.
- SW changing during SHIFT/DONE: the current conversion finishes with the old sample. IDLE then detects the mismatch and starts a new conversion. d0..d3 only ever hold complete results, so no partial digits are shown.
- SW toggling back to last_sw mid-conversion: no reconversion is triggered.
- Scanning runs independently of the converter; digits update atomically in DONE whatever pos is.
- Widths: BCD accumulator is 16 bits; iter counter is ceil(log2(W+1)) bits; cnt is 16 bits.

Test Plan:
- Reset release, SW=0, dp_en=0, SCAN_DIV=5:
  - posb=1111 and num=10 in the first cycle after reset.
  - posb then cycles 1110, 1101, 1011, 0111, each held 6 cycles.
  - num = 0, 10, 10, 10 in the matching slots.
- SW=105 applied at idle:
  - busy high for 14 cycles, and d0..d3 update at cycle 15.
  - Slots then show num 5 (pos0), 0 (pos1), 1 (pos2), 10 (pos3).
- SW=8191, then SW=7:
  - 8191 shows 1, 9, 1, 8 with no blanks.
  - 7 shows 7, 10, 10, 10.
  - Check every 13-bit value against a reference model through exhaustive sweep.
- SW changed 3->42 while busy (cycle 5 of the conversion of 3):
  - Display shows 3 first, then 42.
  - Intermediate num values are only ever 3 or 42 digit codes.
  - busy drops for exactly 1 cycle between the two conversions.
- dp_en=4'b0100 with SW=1234:
  - dp=1 only while posb=1011, and 0 in all other slots.
- RST asserted for 1 cycle mid-SHIFT and mid-scan (pos=2, cnt=3):
  - Next cycle: posb=1111, num=10, busy=0, cnt=0, pos=0.
  - The forced conversion of the current SW completes W+2 cycles after RST deasserts.
